// File: rtl/switch_alloc_rr.sv
// N-port round-robin switch allocator with a registered crossbar output stage.
// Define SWITCH_ALLOC_LOCK_EN to hold an output for one input from head flit to tail flit.
module switch_alloc_rr #(
    parameter int NPORTS   = 5,
    parameter int DATASIZE = 40
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NPORTS*NPORTS-1:0]     in_req,
    input  logic [NPORTS*DATASIZE-1:0]   in_data,
    output logic [NPORTS-1:0]            in_ready,
    input  logic [NPORTS-1:0]            out_full,
    output logic [NPORTS-1:0]            out_valid,
    output logic [NPORTS*DATASIZE-1:0]   out_data,
    output logic [NPORTS*NPORTS-1:0]     out_grant
);

    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam logic [NPORTS-1:0] N_ONE  = NPORTS'(1);
    localparam logic [PW-1:0]     PW_ONE = PW'(1);
    localparam logic [PW-1:0]     PW_MAX = PW'(NPORTS - 1);

    logic [NPORTS-1:0]   dest     [NPORTS];
    logic [NPORTS-1:0]   req      [NPORTS];
    logic [NPORTS-1:0]   elig     [NPORTS];
    logic [PW-1:0]       cand     [NPORTS][NPORTS];
    logic [NPORTS-1:0]   grant    [NPORTS];
    logic                hit      [NPORTS];
    logic [PW-1:0]       win      [NPORTS];
    logic [DATASIZE-1:0] flit_sel [NPORTS];

    logic [PW-1:0]       ptr_q    [NPORTS];
    logic [PW-1:0]       ptr_d    [NPORTS];
    logic                valid_q  [NPORTS];
    logic                valid_d  [NPORTS];
    logic [DATASIZE-1:0] data_q   [NPORTS];
    logic [DATASIZE-1:0] data_d   [NPORTS];

`ifdef SWITCH_ALLOC_LOCK_EN
    logic                lock_valid_q [NPORTS];
    logic                lock_valid_d [NPORTS];
    logic [PW-1:0]       lock_owner_q [NPORTS];
    logic [PW-1:0]       lock_owner_d [NPORTS];
`endif

    // x & -x isolates the lowest set bit, so multi-hot requests collapse to one destination
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            dest[i] = in_req[i*NPORTS +: NPORTS] & (~in_req[i*NPORTS +: NPORTS] + N_ONE);
        end
    end

    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            req[o] = '0;
            for (int i = 0; i < NPORTS; i++) begin
                req[o][i] = dest[i][o];
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            elig[o] = '0;
            for (int i = 0; i < NPORTS; i++) begin
`ifdef SWITCH_ALLOC_LOCK_EN
                elig[o][i] = req[o][i] &
                             (~lock_valid_q[o] | (lock_owner_q[o] == PW'(i)));
`else
                elig[o][i] = req[o][i];
`endif
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            for (int k = 0; k < NPORTS; k++) begin
                cand[o][k] = PW'((int'(ptr_q[o]) + k) % NPORTS);
            end
        end
    end

    // Search order starts at the pointer; a full output or active reset grants nothing
    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            grant[o] = '0;
            hit[o]   = 1'b0;
            win[o]   = '0;
            if (rst_n && !out_full[o]) begin
                for (int k = 0; k < NPORTS; k++) begin
                    if (!hit[o] && elig[o][cand[o][k]]) begin
                        hit[o]               = 1'b1;
                        win[o]               = cand[o][k];
                        grant[o][cand[o][k]] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            flit_sel[o] = '0;
            for (int i = 0; i < NPORTS; i++) begin
                if (grant[o][i]) begin
                    flit_sel[o] = in_data[i*DATASIZE +: DATASIZE];
                end
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            ptr_d[o]   = ptr_q[o];
            valid_d[o] = valid_q[o];
            data_d[o]  = data_q[o];
`ifdef SWITCH_ALLOC_LOCK_EN
            lock_valid_d[o] = lock_valid_q[o];
            lock_owner_d[o] = lock_owner_q[o];
`endif
            if (!out_full[o]) begin
                valid_d[o] = hit[o];
                data_d[o]  = flit_sel[o];
            end
            if (hit[o]) begin
                ptr_d[o] = (win[o] == PW_MAX) ? '0 : win[o] + PW_ONE;
`ifdef SWITCH_ALLOC_LOCK_EN
                // head claims the output, tail releases it; single and body leave it alone
                case (flit_sel[o][1:0])
                    2'b00: begin
                        lock_valid_d[o] = 1'b1;
                        lock_owner_d[o] = win[o];
                    end
                    2'b10:   lock_valid_d[o] = 1'b0;
                    default: ;
                endcase
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int o = 0; o < NPORTS; o++) begin
                ptr_q[o]   <= '0;
                valid_q[o] <= 1'b0;
                data_q[o]  <= '0;
`ifdef SWITCH_ALLOC_LOCK_EN
                lock_valid_q[o] <= 1'b0;
                lock_owner_q[o] <= '0;
`endif
            end
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                ptr_q[o]   <= ptr_d[o];
                valid_q[o] <= valid_d[o];
                data_q[o]  <= data_d[o];
`ifdef SWITCH_ALLOC_LOCK_EN
                lock_valid_q[o] <= lock_valid_d[o];
                lock_owner_q[o] <= lock_owner_d[o];
`endif
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int o = 0; o < NPORTS; o++) begin
            out_valid[o]                        = valid_q[o];
            out_data[o*DATASIZE +: DATASIZE]    = data_q[o];
            out_grant[o*NPORTS +: NPORTS]       = grant[o];
            in_ready                            = in_ready | grant[o];
        end
    end

endmodule

// File: tb/tb_switch_alloc_rr.sv
// Randomized bench for switch_alloc_rr with a behavioural allocator model and directed literal checks.
module tb_switch_alloc_rr;

    localparam int N = 5;
    localparam int D = 40;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N*N-1:0]   in_req;
    logic [N*D-1:0]   in_data;
    logic [N-1:0]     in_ready;
    logic [N-1:0]     out_full;
    logic [N-1:0]     out_valid;
    logic [N*D-1:0]   out_data;
    logic [N*N-1:0]   out_grant;

    int n_pass  = 0;
    int n_total = 0;

    switch_alloc_rr #(.NPORTS(N), .DATASIZE(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_req    (in_req),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_full  (out_full),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_grant (out_grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Model state: what each output register and pointer must hold
    int             m_ptr   [N] = '{default: 0};
    bit             m_valid [N] = '{default: 0};
    logic [D-1:0]   m_data  [N] = '{default: '0};
    bit             m_lv    [N] = '{default: 0};
    int             m_lo    [N] = '{default: 0};
    int             m_win   [N] = '{default: -1};

    always @(negedge clk) begin : cmp
        int md [N];
        int best;
        int d;
        logic [N*N-1:0] eg;
        logic [N-1:0]   er;
        logic [N-1:0]   ev;
        logic [N*D-1:0] ed;
        eg = '0; er = '0; ev = '0; ed = '0;
        for (int i = 0; i < N; i++) begin
            md[i] = -1;
            for (int o = 0; o < N; o++)
                if (md[i] < 0 && in_req[i*N+o]) md[i] = o;
        end
        for (int o = 0; o < N; o++) begin
            m_win[o] = -1;
            best = N;
            if (rst_n && !out_full[o]) begin
                for (int i = 0; i < N; i++) begin
                    bit ok;
                    ok = (md[i] == o);
`ifdef SWITCH_ALLOC_LOCK_EN
                    if (m_lv[o] && m_lo[o] != i) ok = 0;
`endif
                    d = (i - m_ptr[o] + N) % N;
                    if (ok && d < best) begin
                        best = d;
                        m_win[o] = i;
                    end
                end
            end
            if (m_win[o] >= 0) begin
                eg[o*N + m_win[o]] = 1'b1;
                er[m_win[o]] = 1'b1;
            end
            ev[o] = m_valid[o];
            ed[o*D +: D] = m_data[o];
        end
        chk("grant", out_grant, eg);
        chk("ready", in_ready, er);
        chk("valid", out_valid, ev);
        chk("data", out_data, ed);
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int o = 0; o < N; o++) begin
                m_ptr[o] = 0; m_valid[o] = 0; m_data[o] = '0; m_lv[o] = 0; m_lo[o] = 0;
            end
        end else begin
            for (int o = 0; o < N; o++) begin
                if (!out_full[o]) begin
                    m_valid[o] = (m_win[o] >= 0);
                    m_data[o]  = (m_win[o] >= 0) ? in_data[m_win[o]*D +: D] : '0;
                    if (m_win[o] >= 0) begin
                        logic [1:0] t;
                        m_ptr[o] = (m_win[o] + 1) % N;
                        t = in_data[m_win[o]*D +: 2];
                        if (t == 2'b00) begin
                            m_lv[o] = 1; m_lo[o] = m_win[o];
                        end else if (t == 2'b10) begin
                            m_lv[o] = 0;
                        end
                    end
                end
            end
        end
    end

    function automatic logic [D-1:0] fl(input int i);
        return {24'hC0DE00, 8'(i), 8'h03};
    endfunction

    task automatic to_neg(); @(negedge clk); #1; endtask
    task automatic to_pos(); @(posedge clk); #1; endtask

    initial begin
        int exp_rr [4];
        int exp_lk [6];
        logic [D-1:0] f1 [3];
        int p;
        exp_rr = '{0, 2, 4, 0};
`ifdef SWITCH_ALLOC_LOCK_EN
        exp_lk = '{1, 1, 1, 2, 2, 2};
`else
        exp_lk = '{1, 2, 1, 2, 1, 2};
`endif
        f1 = '{40'h1100, 40'h2201, 40'h3302};

        rst_n    = 1'b0;
        out_full = '0;
        in_req   = {N{5'b00001}};
        for (int i = 0; i < N; i++) in_data[i*D +: D] = fl(i);

        to_pos();
        to_neg();
        chk("rst_ready", in_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_grant", out_grant, 0);
        to_pos();
        rst_n = 1'b1;
        to_neg();
        chk("first_grant", out_grant[4:0], 5'b00001);
        to_pos();

        in_req = '0;
        in_req[0*N+1] = 1'b1; in_req[2*N+1] = 1'b1; in_req[4*N+1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            to_neg();
            chk("rr_grant", out_grant[N +: N], 5'(1) << exp_rr[k]);
            to_pos();
            chk("rr_data", out_data[D +: D], fl(exp_rr[k]));
        end

        in_req = '0;
        in_req[1*N+2] = 1'b1;
        in_data[1*D +: D] = 40'h3333;
        to_neg();
        chk("bp_pre_ready", in_ready[1], 1'b1);
        to_pos();
        chk("bp_pre_data", out_data[2*D +: D], 40'h3333);
        in_req = '0;
        in_req[3*N+2] = 1'b1;
        in_data[3*D +: D] = 40'hA5;
        out_full[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            to_neg();
            chk("bp_ready", in_ready[3], 1'b0);
            to_pos();
            chk("bp_hold_valid", out_valid[2], 1'b1);
            chk("bp_hold_data", out_data[2*D +: D], 40'h3333);
        end
        out_full[2] = 1'b0;
        to_neg();
        chk("bp_release_ready", in_ready[3], 1'b1);
        to_pos();
        chk("bp_release_data", out_data[2*D +: D], 40'hA5);
        chk("bp_release_valid", out_valid[2], 1'b1);

        in_req = '0;
        in_data[0*D +: D] = fl(0);
        in_data[4*D +: D] = fl(4);
        in_req[0*N+4] = 1'b1; in_req[4*N+0] = 1'b1;
        to_neg();
        chk("par_ready", in_ready & 5'b10001, 5'b10001);
        to_pos();
        chk("par_valid", out_valid & 5'b10001, 5'b10001);
        chk("par_data0", out_data[0 +: D], fl(4));
        chk("par_data4", out_data[4*D +: D], fl(0));

        in_req = '0;
        p = 0;
        for (int c = 0; c < 6; c++) begin
            in_req[1*N+3] = (p < 3);
            in_data[1*D +: D] = (p < 3) ? f1[p] : '0;
            in_req[2*N+3] = 1'b1;
            in_data[2*D +: D] = 40'h4403;
            to_neg();
            chk("lock_grant", out_grant[3*N +: N], 5'(1) << exp_lk[c]);
            if (in_ready[1]) p++;
            to_pos();
        end

        for (int c = 0; c < 1500; c++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            for (int i = 0; i < N; i++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 3)      in_req[i*N +: N] = '0;
                else if (r < 8) in_req[i*N +: N] = 5'(1) << $urandom_range(0, N-1);
                else            in_req[i*N +: N] = 5'($urandom);
                in_data[i*D +: D] = {8'($urandom), 32'($urandom)};
                out_full[i] = ($urandom_range(0, 3) == 0);
            end
            to_pos();
        end
        rst_n = 1'b1;
        in_req = '0;
        to_pos();
        to_neg();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/switch_alloc_rr.md
# switch_alloc_rr

Parametrised N-port switch allocator and crossbar for the mesh router, placed between the input VC/FIFO stage and the output links. It arbitrates per output port with a round-robin pointer, steers the winning input's flit through a registered crossbar stage, and back-pressures both inputs and outputs via ready/full handshakes. An optional wormhole lock keeps an output dedicated to one input from head flit to tail flit.

## Interface

**Parameters**
- `NPORTS`, default 5: number of router ports, each used as both input and output. Index 0 is Local.
- `DATASIZE`, default 40: flit width. The flit type is `data[1:0]`: 00 head, 01 body, 10 tail, 11 single.

**Ports**
- `clk`, input, 1: the only clock. All state updates on its rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `in_req`, input, NPORTS*NPORTS: slice `[i*NPORTS +: NPORTS]` is the one-hot destination of input i. All-zero means no request. If more than one bit is set, only the lowest set bit is used.
- `in_data`, input, NPORTS*DATASIZE: flit of input i, in slice `[i*DATASIZE +: DATASIZE]`.
- `in_ready`, output, NPORTS: combinational. 1 when input i's flit is taken this cycle, and the source pops on this.
- `out_full`, input, NPORTS: downstream of output o cannot accept.
- `out_valid`, output, NPORTS: registered valid for output o.
- `out_data`, output, NPORTS*DATASIZE: registered flit for output o.
- `out_grant`, output, NPORTS*NPORTS: combinational grant matrix. Slice `[o*NPORTS +: NPORTS]` is one-hot, holding the input granted to output o this cycle.

## Operation

- **Request decode.** `req[o][i]` is 1 when input i's effective destination is o.
- **Output eligibility.** Output o is eligible when `out_full[o]` = 0. An ineligible output grants nothing and holds its register.
- **Round-robin arbitration.** Each output o has a pointer `ptr[o]` of width `$clog2(NPORTS)`.
  - The search starts at input `ptr[o]`, then `ptr[o]+1`, and so on, wrapping modulo NPORTS. The first requesting input wins.
  - On a grant to input i: `ptr[o] <= (i+1) mod NPORTS`. Without a grant, the pointer holds.
  - Wrap: with NPORTS=5 and a grant to input 4, the pointer becomes 0.
- **Input ready.** `in_ready[i]` = OR over o of `out_grant[o][i]`. Because requests are one-hot, an input is granted by at most one output.
- **Output register.** When `out_full[o]` = 0:
  - `out_valid[o] <=` (any grant to o).
  - `out_data[o] <=` the granted input's data, or all-zero when there is no grant.
  - When `out_full[o]` = 1: `out_valid[o]` and `out_data[o]` hold.
- **Downstream transfer.** Downstream consumes a flit on any cycle where `out_valid` = 1 and `out_full` = 0.
- **Simultaneous events.** Several inputs requesting different outputs are all granted in the same cycle. An input requesting a full output waits, with `in_ready` = 0.
- **Reset.** With `rst_n` = 0 at a clock edge:
  - `out_valid` = 0, `out_data` = 0, all `ptr` = 0, all locks cleared.
  - `in_ready` and `out_grant` are forced to 0 while `rst_n` = 0.
  - A flit in flight during a mid-operation reset is discarded.

## Timing

- Request to `in_ready`/`out_grant`: combinational, same cycle.
- Grant to `out_valid`/`out_data`: 1 cycle.
- Throughput: 1 flit per output per cycle while `out_full` = 0.
- `out_full` is sampled in the same cycle as the grant. No skid buffering.
- The pointer and lock update on the same edge as the output register.

## Configuration

- Macro: `SWITCH_ALLOC_LOCK_EN`.
- **Defined (wormhole lock).** Each output keeps `lock_valid[o]` and `lock_owner[o]`.
  - Granting a head flit (00) sets the lock to the granted input.
  - While locked, only `lock_owner[o]` may be granted o. Other requesters are masked.
  - Granting a tail flit (10) clears the lock.
  - A single flit (11) neither sets nor clears a lock.
  - A body or tail flit arriving at an unlocked output arbitrates normally.
  - Pointers update on every grant.
  - While the output is full, the lock holds.
- **Undefined.** No lock state. Every flit arbitrates independently and `data[1:0]` is ignored.

## Test plan

- **Reset:** Hold `rst_n` = 0 for 2 cycles with all inputs requesting. Required: `out_valid` = 0, `out_data` = 0, `in_ready` = 0, and after release the first grant goes to input 0.
- **Round-robin:** NPORTS=5, inputs 0, 2 and 4 continuously request output 1, with `out_full` = 0. Required: grants 0, 2, 4, 0, ... on consecutive cycles, and `out_data[1]` shows each input's flit 1 cycle later.
- **Back-pressure:** Input 3 sends 0xA5 to output 2 while `out_full[2]` = 1 for 3 cycles. Required: `in_ready[3]` = 0 and `out_valid[2]` holds its prior value. When full drops, the grant happens and `out_data[2]` = 0xA5 the next cycle.
- **Parallel paths:** Input 0 requests output 4 and input 4 requests output 0 in the same cycle. Required: both `in_ready` = 1 and both outputs valid on the next cycle.
- **Wormhole lock (`SWITCH_ALLOC_LOCK_EN`):** Input 1 sends head, body, tail to output 3 while input 2 also requests output 3. Required: input 2 is blocked until the cycle after the tail is granted. Without the macro, inputs 1 and 2 interleave.
